// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the execute-stage results, write-back controls and load/store
// information for the MEM stage. It also returns the partial multi-cycle
// (multiply-accumulate / divide) state to EX so an interrupted op can resume.
//
// Stall/flush handling, evaluated once per rising edge, highest priority first:
//   flush                   : clear every output, including hilo_o/cnt_o
//   stall[3] & ~stall[4]    : bubble; mem_* cleared, hilo/cnt captured from EX
//   ~stall[3]               : advance; mem_* <= ex_*, hilo/cnt cleared
//   stall[3] &  stall[4]    : hold every output
// The combination ~stall[3] & stall[4] cannot occur in a healthy pipeline.
// It falls into the advance case, because the EX stage is moving.
//
// Handshake note: this block has no valid/ready pair. A bubble is encoded
// as wreg=0, whilo=0 and aluop=NOP. Downstream stages treat such an entry as
// carrying no work.
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [RADDR_W-1:0]    ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [OP_W-1:0]       ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [RADDR_W-1:0]    mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [OP_W-1:0]       mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  // Registered state
  logic [RADDR_W-1:0]  r_wd;
  logic                r_wreg;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_whilo;
  logic [OP_W-1:0]     r_aluop;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_reg2;
  logic [2*DATA_W-1:0] r_hilo;
  logic [1:0]          r_cnt;

  // Per-edge action decode; exactly one of these is high
  logic w_do_flush;
  logic w_do_bubble;
  logic w_do_advance;
  logic w_do_hold;

  // Decode the stall vector and flush into a single one-hot action
  always_comb begin
    w_do_flush   = 1'b0;
    w_do_bubble  = 1'b0;
    w_do_advance = 1'b0;
    w_do_hold    = 1'b0;
    if (flush) begin
      w_do_flush = 1'b1;
    end else if (stall[3] && !stall[4]) begin
      w_do_bubble = 1'b1;
    end else if (!stall[3]) begin
      w_do_advance = 1'b1;
    end else begin
      w_do_hold = 1'b1;
    end
  end

  // Write-back controls: cleared on flush/bubble so no write is ever duplicated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_whilo <= 1'b0;
      r_aluop <= '0;
    end else if (w_do_flush || w_do_bubble) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_whilo <= 1'b0;
      r_aluop <= '0;
    end else if (w_do_advance) begin
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_whilo <= ex_whilo;
      r_aluop <= ex_aluop;
    end
  end

  // Data payload: result, HI/LO values, effective address and store data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdata    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mem_addr <= '0;
      r_reg2     <= '0;
    end else if (w_do_flush || w_do_bubble) begin
      r_wdata    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mem_addr <= '0;
      r_reg2     <= '0;
    end else if (w_do_advance) begin
      r_wdata    <= ex_wdata;
      r_hi       <= ex_hi;
      r_lo       <= ex_lo;
      r_mem_addr <= ex_mem_addr;
      r_reg2     <= ex_reg2;
    end
  end

  // Multi-cycle feedback: kept only while EX is stalled and MEM drains a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hilo <= '0;
      r_cnt  <= 2'd0;
    end else if (w_do_flush || w_do_advance) begin
      r_hilo <= '0;
      r_cnt  <= 2'd0;
    end else if (w_do_bubble) begin
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end
  end

  // In the hold case no register updates. w_do_hold documents this and stays observable.
  logic w_unused;
  assign w_unused = w_do_hold ^ (|stall[5]) ^ (|stall[2:0]);

  assign mem_wd       = r_wd;
  assign mem_wreg     = r_wreg;
  assign mem_wdata    = r_wdata;
  assign mem_hi       = r_hi;
  assign mem_lo       = r_lo;
  assign mem_whilo    = r_whilo;
  assign mem_aluop    = r_aluop;
  assign mem_mem_addr = r_mem_addr;
  assign mem_reg2     = r_reg2;
  assign hilo_o       = r_hilo;
  assign cnt_o        = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed testbench for ex_mem_reg.
// The inputs are driven 1 ns after each rising edge. The outputs are sampled
// 1 ns after the edge. All expected values are hand-computed constants.
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_tests;
  int n_fail;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task: every comparison goes through here
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the full EX bundle
  task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                          input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo;
    ex_whilo = whilo; ex_aluop = aluop; ex_mem_addr = addr; ex_reg2 = reg2;
  endtask

  // Drive the T2 reference vector
  task automatic drive_t2();
    drive_ex(5'd3, 1'b1, 32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444, 1'b1,
             8'h23, 32'h0000_0100, 32'hCAFE_F00D);
  endtask

  // Compare every MEM output against the T2 reference vector
  task automatic check_t2(input string pfx);
    check({pfx, ".wd"},    {59'd0, mem_wd},    64'd3);
    check({pfx, ".wreg"},  {63'd0, mem_wreg},  64'd1);
    check({pfx, ".wdata"}, {32'd0, mem_wdata}, 64'hDEADBEEF);
    check({pfx, ".hi"},    {32'd0, mem_hi},    64'h1111_2222);
    check({pfx, ".lo"},    {32'd0, mem_lo},    64'h3333_4444);
    check({pfx, ".whilo"}, {63'd0, mem_whilo}, 64'd1);
    check({pfx, ".aluop"}, {56'd0, mem_aluop}, 64'h23);
    check({pfx, ".addr"},  {32'd0, mem_mem_addr}, 64'h100);
    check({pfx, ".reg2"},  {32'd0, mem_reg2},  64'hCAFE_F00D);
  endtask

  // Compare every output against zero
  task automatic check_zero(input string pfx);
    check({pfx, ".wd"},    {59'd0, mem_wd},    64'd0);
    check({pfx, ".wreg"},  {63'd0, mem_wreg},  64'd0);
    check({pfx, ".wdata"}, {32'd0, mem_wdata}, 64'd0);
    check({pfx, ".hi"},    {32'd0, mem_hi},    64'd0);
    check({pfx, ".lo"},    {32'd0, mem_lo},    64'd0);
    check({pfx, ".whilo"}, {63'd0, mem_whilo}, 64'd0);
    check({pfx, ".aluop"}, {56'd0, mem_aluop}, 64'd0);
    check({pfx, ".addr"},  {32'd0, mem_mem_addr}, 64'd0);
    check({pfx, ".reg2"},  {32'd0, mem_reg2},  64'd0);
    check({pfx, ".hilo"},  hilo_o,             64'd0);
    check({pfx, ".cnt"},   {62'd0, cnt_o},     64'd0);
  endtask

  // Stimulus and report
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; stall = 6'd0; flush = 1'b0;
    drive_ex('0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    hilo_i = '0; cnt_i = 2'd0;
    #12;
    check_zero("rst_init");
    rst = 1'b1;
    @(posedge clk); #1;

    // T2 pass-through
    drive_t2();
    tick();
    check_t2("t2");
    check("t2.hilo", hilo_o, 64'd0);
    check("t2.cnt", {62'd0, cnt_o}, 64'd0);

    // T1a: asynchronous reset mid-cycle with mem outputs nonzero
    #2 rst = 1'b0;
    #1 check_zero("t1_async");
    drive_ex('0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    #3 rst = 1'b1;
    tick();
    check_zero("t1_post1");
    tick();
    check_zero("t1_post2");

    // T1b: reset in the middle of a multi-cycle op clears hilo_o/cnt_o
    stall = 6'b001111; hilo_i = 64'hAAAA_5555_1234_5678; cnt_i = 2'd2;
    tick();
    check("t1b.hilo_pre", hilo_o, 64'hAAAA_5555_1234_5678);
    #2 rst = 1'b0;
    #1 check("t1b.hilo", hilo_o, 64'd0);
    check("t1b.cnt", {62'd0, cnt_o}, 64'd0);
    stall = 6'd0; hilo_i = '0; cnt_i = 2'd0;
    #3 rst = 1'b1;
    tick();

    // T3 bubble
    drive_t2();
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    tick();
    check("t3.wreg",  {63'd0, mem_wreg},  64'd0);
    check("t3.whilo", {63'd0, mem_whilo}, 64'd0);
    check("t3.wdata", {32'd0, mem_wdata}, 64'd0);
    check("t3.aluop", {56'd0, mem_aluop}, 64'd0);
    check("t3.hilo",  hilo_o,             64'h1_0000_0002);
    check("t3.cnt",   {62'd0, cnt_o},     64'd1);

    // T6 resume after the bubble
    stall = 6'd0; ex_wdata = 32'h5;
    tick();
    check("t6.wdata", {32'd0, mem_wdata}, 64'h5);
    check("t6.wreg",  {63'd0, mem_wreg},  64'd1);
    check("t6.hilo",  hilo_o,             64'd0);
    check("t6.cnt",   {62'd0, cnt_o},     64'd0);

    // T4 hold of the mem_* outputs over 3 edges while ex_* changes
    drive_t2();
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_ex(5'(i + 9), 1'b0, 32'(i * 7 + 1), 32'hFFFF_0000, 32'h0000_FFFF,
               1'b0, 8'h40, 32'h2000, 32'h77);
      tick();
      check_t2($sformatf("t4.hold%0d", i));
    end

    // T4b: the feedback state also holds over 3 edges while hilo_i/cnt_i change
    stall = 6'b001111; hilo_i = 64'hFEED_0000_BEEF_0001; cnt_i = 2'd3;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      hilo_i = 64'(i + 100); cnt_i = 2'(i);
      tick();
      check($sformatf("t4b.hilo%0d", i), hilo_o, 64'hFEED_0000_BEEF_0001);
      check($sformatf("t4b.cnt%0d", i), {62'd0, cnt_o}, 64'd3);
    end

    // T5 flush overrides a full stall; the mem outputs are loaded beforehand
    stall = 6'd0; drive_t2();
    tick();
    check("t5.wreg_pre", {63'd0, mem_wreg}, 64'd1);
    stall = 6'b011111; flush = 1'b1;
    tick();
    check_zero("t5");

    // Flush clears the feedback state as well
    flush = 1'b0; stall = 6'b001111; hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd2;
    tick();
    check("t5b.cnt_pre", {62'd0, cnt_o}, 64'd2);
    flush = 1'b1;
    tick();
    check("t5b.hilo", hilo_o, 64'd0);
    check("t5b.cnt", {62'd0, cnt_o}, 64'd0);
    flush = 1'b0;

    // An illegal stall pattern (EX moving, MEM stalled) acts as an advance
    stall = 6'b010000;
    drive_ex(5'd31, 1'b1, 32'h8000_0001, 32'h0, 32'h1, 1'b0, 8'hFF, 32'hFFFF_FFFC, 32'h1);
    tick();
    check("ill.wd",    {59'd0, mem_wd},    64'd31);
    check("ill.wdata", {32'd0, mem_wdata}, 64'h8000_0001);
    check("ill.aluop", {56'd0, mem_aluop}, 64'hFF);
    check("ill.addr",  {32'd0, mem_mem_addr}, 64'hFFFF_FFFC);
    check("ill.hilo",  hilo_o,             64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
